// File: rtl/operand_stack.sv
// LIFO operand stack: top-of-stack held in a register, deeper entries in an
// inferred block RAM with registered read. PUSH/POP/REPLACE/DUP with fault pulses.
module operand_stack #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 65536,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trigger,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] write_value,
  output logic [DATA_W-1:0] read_value,
  output logic [DATA_W-1:0] top_value,
  output logic [ADDR_W:0]   depth,
  output logic              empty,
  output logic              full,
  output logic              busy,
  output logic              done_out,
  output logic              error_out
);

  typedef enum logic [1:0] {
    OP_PUSH    = 2'b00,
    OP_POP     = 2'b01,
    OP_REPLACE = 2'b10,
    OP_DUP     = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    POP_WAIT,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] TWO      = (ADDR_W+1)'(2);

  state_t              state, state_next;
  op_t                 op_q;
  logic [DATA_W-1:0]   wv_q;
  logic [DATA_W-1:0]   tos;
  logic [DATA_W-1:0]   rd_val;
  logic [ADDR_W:0]     cnt;
  logic                done_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem [DEPTH-1];
  logic [DATA_W-1:0]   ram_q;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;

  logic                accept;
  logic                fault;
  logic                is_empty;
  logic                is_full;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign accept   = trigger && (state == IDLE || state == DONE);

  always_comb begin
    fault = 1'b0;
    unique case (op_q)
      OP_PUSH:    fault = is_full;
      OP_POP:     fault = is_empty;
      OP_REPLACE: fault = is_empty;
      OP_DUP:     fault = is_empty || is_full;
      default:    fault = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: state_next = accept ? EXEC : IDLE;
      EXEC:       state_next = (!fault && op_q == OP_POP) ? POP_WAIT : DONE;
      POP_WAIT:   state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  // Writes spill TOS to slot depth-1; a POP reads the new top from depth-2.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = ADDR_W'(cnt - ONE);
    if (state == EXEC && !fault) begin
      if (op_q == OP_POP) begin
        ram_addr = ADDR_W'(cnt - TWO);
      end else if ((op_q == OP_PUSH || op_q == OP_DUP) && !is_empty) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ram_we) begin
      mem[ram_addr] <= tos;
    end
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= OP_PUSH;
      wv_q   <= '0;
      tos    <= '0;
      rd_val <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        op_q <= op_t'(op);
        wv_q <= write_value;
      end
      unique case (state)
        EXEC: begin
          if (fault) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            unique case (op_q)
              OP_PUSH: begin
                tos    <= wv_q;
                cnt    <= cnt + ONE;
                done_q <= 1'b1;
              end
              OP_DUP: begin
                cnt    <= cnt + ONE;
                done_q <= 1'b1;
              end
              OP_REPLACE: begin
                tos    <= wv_q;
                done_q <= 1'b1;
              end
              OP_POP: rd_val <= tos;
              default: ;
            endcase
          end
        end
        // RAM read data is valid now; depth still reflects the pre-POP count.
        POP_WAIT: begin
          tos    <= (cnt > ONE) ? ram_q : '0;
          cnt    <= cnt - ONE;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign read_value = rd_val;
  assign top_value  = tos;
  assign depth      = cnt;
  assign empty      = is_empty;
  assign full       = is_full;
  assign busy       = (state == EXEC) || (state == POP_WAIT);
  assign done_out   = done_q;
  assign error_out  = err_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack (DEPTH=4): latency, ordering, faults,
// trigger-while-busy and reset during POP_WAIT.
module tb_operand_stack;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] PUSH    = 2'b00;
  localparam logic [1:0] POP     = 2'b01;
  localparam logic [1:0] REPLACE = 2'b10;
  localparam logic [1:0] DUP     = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              trigger;
  logic [1:0]        op;
  logic [DATA_W-1:0] write_value;
  logic [DATA_W-1:0] read_value;
  logic [DATA_W-1:0] top_value;
  logic [ADDR_W:0]   depth;
  logic              empty;
  logic              full;
  logic              busy;
  logic              done_out;
  logic              error_out;

  int checks   = 0;
  int failures = 0;

  operand_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger     (trigger),
    .op          (op),
    .write_value (write_value),
    .read_value  (read_value),
    .top_value   (top_value),
    .depth       (depth),
    .empty       (empty),
    .full        (full),
    .busy        (busy),
    .done_out    (done_out),
    .error_out   (error_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Trigger issued immediately (may fall in the previous op's done cycle).
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                       input int exp_lat, input logic exp_err);
    int lat;
    trigger     = 1'b1;
    op          = o;
    write_value = v;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_out) break;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".err"}, 64'(error_out), 64'(exp_err));
    chk({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; op = PUSH; write_value = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.depth", 64'(depth), 64'(0));
    chk("rst.top", 64'(top_value), 64'(0));
    chk("rst.read", 64'(read_value), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done_out), 64'(0));
    chk("rst.err", 64'(error_out), 64'(0));
    chk("rst.empty", 64'(empty), 64'(1));
    chk("rst.full", 64'(full), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("pushA", PUSH, 32'hA, 1, 1'b0);
    do_op("pushB", PUSH, 32'hB, 1, 1'b0);
    do_op("pushC", PUSH, 32'hC, 1, 1'b0);
    chk("abc.top", 64'(top_value), 64'hC);
    chk("abc.depth", 64'(depth), 64'(3));

    do_op("pop1", POP, 0, 2, 1'b0);
    chk("pop1.read", 64'(read_value), 64'hC);
    chk("pop1.top", 64'(top_value), 64'hB);
    do_op("pop2", POP, 0, 2, 1'b0);
    chk("pop2.read", 64'(read_value), 64'hB);
    chk("pop2.top", 64'(top_value), 64'hA);
    do_op("pop3", POP, 0, 2, 1'b0);
    chk("pop3.read", 64'(read_value), 64'hA);
    chk("pop3.top", 64'(top_value), 64'h0);
    chk("pop3.empty", 64'(empty), 64'(1));

    do_op("popE", POP, 0, 1, 1'b1);
    chk("popE.depth", 64'(depth), 64'(0));
    chk("popE.read", 64'(read_value), 64'hA);
    do_op("repE", REPLACE, 32'h5, 1, 1'b1);
    chk("repE.depth", 64'(depth), 64'(0));
    chk("repE.top", 64'(top_value), 64'h0);

    for (int k = 1; k <= 4; k++) do_op("fill", PUSH, 32'(k), 1, 1'b0);
    chk("fill.full", 64'(full), 64'(1));
    chk("fill.depth", 64'(depth), 64'(4));
    do_op("ovf", PUSH, 32'h5, 1, 1'b1);
    chk("ovf.top", 64'(top_value), 64'h4);
    chk("ovf.depth", 64'(depth), 64'(4));
    do_op("dupF", DUP, 0, 1, 1'b1);
    chk("dupF.depth", 64'(depth), 64'(4));
    for (int k = 4; k >= 1; k--) begin
      do_op("drain", POP, 0, 2, 1'b0);
      chk("drain.read", 64'(read_value), 64'(k));
    end
    chk("drain.empty", 64'(empty), 64'(1));

    do_op("push7", PUSH, 32'h7, 1, 1'b0);
    do_op("dup", DUP, 0, 1, 1'b0);
    chk("dup.depth", 64'(depth), 64'(2));
    chk("dup.top", 64'(top_value), 64'h7);
    do_op("rep9", REPLACE, 32'h9, 1, 1'b0);
    chk("rep9.top", 64'(top_value), 64'h9);
    chk("rep9.depth", 64'(depth), 64'(2));
    do_op("popR", POP, 0, 2, 1'b0);
    chk("popR.read", 64'(read_value), 64'h9);
    chk("popR.top", 64'(top_value), 64'h7);
    do_op("popD", POP, 0, 2, 1'b0);
    chk("popD.read", 64'(read_value), 64'h7);
    chk("popD.depth", 64'(depth), 64'(0));

    // Trigger held through EXEC and POP_WAIT must be ignored.
    do_op("push55", PUSH, 32'h55, 1, 1'b0);
    do_op("push66", PUSH, 32'h66, 1, 1'b0);
    trigger = 1'b1; op = POP;
    @(posedge clk);
    #1;
    op = PUSH; write_value = 32'h77;
    @(posedge clk);
    #1;
    chk("ign.busy", 64'(busy), 64'(1));
    chk("ign.done0", 64'(done_out), 64'(0));
    @(posedge clk);
    #1;
    trigger = 1'b0;
    chk("ign.done1", 64'(done_out), 64'(1));
    chk("ign.read", 64'(read_value), 64'h66);
    chk("ign.top", 64'(top_value), 64'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("ign.depth", 64'(depth), 64'(1));
    chk("ign.top2", 64'(top_value), 64'h55);
    chk("ign.busy2", 64'(busy), 64'(0));

    // Reset asserted while the POP is waiting on RAM data.
    do_op("push88", PUSH, 32'h88, 1, 1'b0);
    trigger = 1'b1; op = POP;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    @(posedge clk);
    #1;
    chk("rpw.busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rpw.depth", 64'(depth), 64'(0));
    chk("rpw.top", 64'(top_value), 64'(0));
    chk("rpw.read", 64'(read_value), 64'(0));
    chk("rpw.busy0", 64'(busy), 64'(0));
    chk("rpw.done", 64'(done_out), 64'(0));
    chk("rpw.err", 64'(error_out), 64'(0));
    chk("rpw.empty", 64'(empty), 64'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op("post", PUSH, 32'h3, 1, 1'b0);
    chk("post.top", 64'(top_value), 64'h3);
    chk("post.depth", 64'(depth), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
